fetch_port: RTL and testbench

- Instruction-side memory port: the responder to the prefetch unit's fetch requests.
- Takes the prefetch fetch address (fpc) plus jump/fence flush, issues word reads on the instruction memory bus, and returns ready/rdata to prefetch.
- Holds one response word and speculatively requests the next sequential word.
- Sits between prefetch and the instruction memory/bus arbiter.

---
 rtl/fetch_port_pkg.sv | 59 +++++
 rtl/fetch_port.sv | 128 ++++++++++++
 tb/tb_fetch_port.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_port_pkg.sv
// fetch_port_pkg
//
// Shared types for the instruction-side fetch port:
//   - fetch_state_e        : port state (IDLE, BUSY, DRAIN)
//   - fetch_port_in_type   : bundled inputs (fetch_addr, fetch_flush, mem_ready, mem_rdata)
//   - fetch_port_out_type  : bundled outputs (fetch_ready, fetch_rdata, mem_valid, mem_addr)
//   - fetch_port_reg_type  : complete register state of the port
//   - word_align()         : clears the byte-offset bits of an address
package fetch_port_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam logic [ADDR_W-1:0] WORD_STEP = 32'd4;

   // IDLE : no bus request outstanding
   // BUSY : request outstanding, response is wanted
   // DRAIN: request outstanding, response will be thrown away
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] fetch_addr;
      logic              fetch_flush;
      logic              mem_ready;
      logic [DATA_W-1:0] mem_rdata;
   } fetch_port_in_type;

   typedef struct packed {
      logic              fetch_ready;
      logic [DATA_W-1:0] fetch_rdata;
      logic              mem_valid;
      logic [ADDR_W-1:0] mem_addr;
   } fetch_port_out_type;

   typedef struct packed {
      fetch_state_e      state;
      logic [ADDR_W-1:0] req_addr;
      logic              hold_valid;
      logic [ADDR_W-1:0] hold_addr;
      logic [DATA_W-1:0] hold_data;
   } fetch_port_reg_type;

   localparam fetch_port_reg_type FETCH_PORT_REG_RESET = '{
      state:      IDLE,
      req_addr:   '0,
      hold_valid: 1'b0,
      hold_addr:  '0,
      hold_data:  '0
   };

   // Masking (rather than slicing) keeps every address bit referenced.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_port.sv
// fetch_port
//
// Instruction-side memory port answering the prefetch unit. It keeps one
// response word in a hold register, issues at most one word read at a time
// on the instruction bus, and (with next_line=1) speculatively requests the
// following word as soon as a forwarded response is consumed.
//
// Ports:
//   rst          in   synchronous reset, active low
//   clk          in   clock
//   fetch_addr   in   [31:0] requested byte address from prefetch, bits [1:0] ignored
//   fetch_flush  in   jump/fence: invalidates held and in-flight data
//   fetch_ready  out  fetch_rdata is valid for fetch_addr this cycle
//   fetch_rdata  out  [31:0] instruction word for the current fetch_addr
//   mem_valid    out  bus request valid (from registered state)
//   mem_addr     out  [31:0] bus word address (registered)
//   mem_ready    in   bus response strobe, data valid in the same cycle
//   mem_rdata    in   [31:0] bus read data
module fetch_port
   import fetch_port_pkg::*;
#(
   parameter bit next_line = 1'b1
) (
   input  logic              rst,
   input  logic              clk,
   input  logic [ADDR_W-1:0] fetch_addr,
   input  logic              fetch_flush,
   output logic              fetch_ready,
   output logic [DATA_W-1:0] fetch_rdata,
   output logic              mem_valid,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   fetch_port_in_type  d_in;
   fetch_port_out_type d_out;
   fetch_port_reg_type r_q;
   fetch_port_reg_type r_d;

   logic [ADDR_W-1:0] cur;
   logic              hit;
   logic              byp;

   // Next-state and output logic. The bus-side outputs come straight from
   // registered state so a request, once raised, cannot be withdrawn by
   // anything prefetch does in the same cycle. Bypass beats hold on the
   // data mux; when both match the words are identical anyway.
   always_comb begin
      d_in.fetch_addr  = fetch_addr;
      d_in.fetch_flush = fetch_flush;
      d_in.mem_ready   = mem_ready;
      d_in.mem_rdata   = mem_rdata;

      r_d = r_q;

      cur = word_align(d_in.fetch_addr);
      hit = r_q.hold_valid && (r_q.hold_addr == cur);
      byp = (r_q.state == BUSY) && d_in.mem_ready && (r_q.req_addr == cur);

      d_out.mem_valid   = (r_q.state != IDLE);
      d_out.mem_addr    = r_q.req_addr;
      d_out.fetch_ready = !d_in.fetch_flush && (hit || byp);
      if (d_out.fetch_ready) begin
         d_out.fetch_rdata = byp ? d_in.mem_rdata : r_q.hold_data;
      end else begin
         d_out.fetch_rdata = '0;
      end

      unique case (r_q.state)
         IDLE: begin
            if (!hit || d_in.fetch_flush) begin
               r_d.req_addr = cur;
               r_d.state    = BUSY;
            end
         end
         BUSY: begin
            if (d_in.mem_ready) begin
               if (d_in.fetch_flush) begin
                  r_d.state = IDLE;
               end else begin
                  // A response for an address prefetch has already left is
                  // still kept; the next IDLE cycle decides whether it hits.
                  r_d.hold_valid = 1'b1;
                  r_d.hold_addr  = r_q.req_addr;
                  r_d.hold_data  = d_in.mem_rdata;
                  if (byp && next_line) begin
                     r_d.req_addr = r_q.req_addr + WORD_STEP;
                  end else begin
                     r_d.state = IDLE;
                  end
               end
            end else if (d_in.fetch_flush) begin
               r_d.state = DRAIN;
            end
         end
         DRAIN: begin
            // The stale response ends the drain even if another flush
            // arrives with it; otherwise we would wait forever.
            if (d_in.mem_ready) begin
               r_d.state = IDLE;
            end
         end
         default: begin
            r_d.state = IDLE;
         end
      endcase

      if (d_in.fetch_flush) begin
         r_d.hold_valid = 1'b0;
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q <= FETCH_PORT_REG_RESET;
      end else begin
         r_q <= r_d;
      end
   end

   assign fetch_ready = d_out.fetch_ready;
   assign fetch_rdata = d_out.fetch_rdata;
   assign mem_valid   = d_out.mem_valid;
   assign mem_addr    = d_out.mem_addr;

endmodule

// File: tb/tb_fetch_port.sv
// tb_fetch_port
//
// Bench for fetch_port: directed scenarios followed by a randomized prefetch
// stream, all compared against a transaction-level model of the port
// (one outstanding read, a "discard" mark after a flush, one hold entry).
module tb_fetch_port;

   localparam bit NEXT_LINE = 1'b1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] fetch_addr = '0;
   logic        fetch_flush = 1'b0;
   logic        fetch_ready;
   logic [31:0] fetch_rdata;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic        m_pend;
   logic        m_discard;
   logic [31:0] m_req;
   logic        m_hv;
   logic [31:0] m_ha;
   logic [31:0] m_hd;
   logic        m_ready_exp;

   // Last sampled DUT outputs, used for the directed spot checks
   logic        o_ready;
   logic [31:0] o_rdata;
   logic        o_mvalid;
   logic [31:0] o_maddr;

   fetch_port #(.next_line(NEXT_LINE)) dut (
      .rst         (rst),
      .clk         (clk),
      .fetch_addr  (fetch_addr),
      .fetch_flush (fetch_flush),
      .fetch_ready (fetch_ready),
      .fetch_rdata (fetch_rdata),
      .mem_valid   (mem_valid),
      .mem_addr    (mem_addr),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata)
   );

   // Free-running clock
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h0F13};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs at the falling edge, compares the settled
   // outputs with the model, then advances the model by one clock.
   task automatic applyStimulus(input logic r, input logic [31:0] a, input logic f,
                                input logic mr, input logic [31:0] rd);
      logic [31:0] cur;
      logic        hit;
      logic        byp;
      logic [31:0] e_rdata;
      @(negedge clk);
      rst         = r;
      fetch_addr  = a;
      fetch_flush = f;
      mem_ready   = mr;
      mem_rdata   = rd;
      #1;
      cur = {a[31:2], 2'b00};
      hit = m_hv && (m_ha == cur);
      byp = m_pend && !m_discard && mr && (m_req == cur);
      m_ready_exp = !f && (hit || byp);
      e_rdata = m_ready_exp ? (byp ? rd : m_hd) : 32'h0;

      o_ready  = fetch_ready;
      o_rdata  = fetch_rdata;
      o_mvalid = mem_valid;
      o_maddr  = mem_addr;
      checkOutput("fetch_ready", {31'b0, o_ready}, {31'b0, m_ready_exp});
      checkOutput("fetch_rdata", o_rdata, e_rdata);
      checkOutput("mem_valid", {31'b0, o_mvalid}, {31'b0, m_pend});
      checkOutput("mem_addr", o_maddr, m_req);

      if (!r) begin
         m_pend = 1'b0; m_discard = 1'b0; m_req = '0;
         m_hv = 1'b0; m_ha = '0; m_hd = '0;
      end else begin
         if (!m_pend) begin
            if (!hit || f) begin
               m_pend = 1'b1; m_discard = 1'b0; m_req = cur;
            end
         end else if (mr) begin
            if (m_discard || f) begin
               m_pend = 1'b0;
            end else begin
               m_hv = 1'b1; m_ha = m_req; m_hd = rd;
               if (byp && NEXT_LINE) m_req = m_req + 32'd4;
               else m_pend = 1'b0;
            end
         end else if (f) begin
            m_discard = 1'b1;
         end
         if (f) m_hv = 1'b0;
      end
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   // Directed scenarios, then a randomized prefetch stream with stalls,
   // flushes, off-stream moves and occasional resets.
   initial begin
      logic [31:0] pf;
      logic        f;
      logic        mr;
      m_pend = 1'b0; m_discard = 1'b0; m_req = '0;
      m_hv = 1'b0; m_ha = '0; m_hd = '0; m_ready_exp = 1'b0;

      $display("[TB] reset state");
      doReset();
      checkOutput("rst_mem_valid", {31'b0, o_mvalid}, 32'h0);
      checkOutput("rst_fetch_ready", {31'b0, o_ready}, 32'h0);

      $display("[TB] miss with three wait states");
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
      checkOutput("tp1_mem_valid_c1", {31'b0, o_mvalid}, 32'h1);
      checkOutput("tp1_mem_addr_c1", o_maddr, 32'h100);
      checkOutput("tp1_ready_c1", {31'b0, o_ready}, 32'h0);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
      checkOutput("tp1_ready_c3", {31'b0, o_ready}, 32'h0);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b1, 32'h0000_0013);
      checkOutput("tp1_ready_c4", {31'b0, o_ready}, 32'h1);
      checkOutput("tp1_rdata_c4", o_rdata, 32'h0000_0013);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
      checkOutput("tp1_hold_hit", o_rdata, 32'h0000_0013);

      $display("[TB] reset while busy");
      applyStimulus(1'b0, 32'h100, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b1, 32'hBAD0_0000);
      checkOutput("rstbusy_mem_valid", {31'b0, o_mvalid}, 32'h0);
      checkOutput("rstbusy_ready", {31'b0, o_ready}, 32'h0);

      $display("[TB] sequential stream");
      doReset();
      applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h200, 1'b0, 1'b1, mem_word(32'h200));
      applyStimulus(1'b1, 32'h204, 1'b0, 1'b1, mem_word(32'h204));
      checkOutput("tp2_ready_204", {31'b0, o_ready}, 32'h1);
      checkOutput("tp2_addr_204", o_maddr, 32'h204);
      applyStimulus(1'b1, 32'h208, 1'b0, 1'b1, mem_word(32'h208));
      checkOutput("tp2_rdata_208", o_rdata, mem_word(32'h208));
      checkOutput("tp2_addr_208", o_maddr, 32'h208);

      $display("[TB] flush mid-flight");
      doReset();
      applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h300, 1'b0, 1'b1, 32'h0000_0300);
      checkOutput("tp3_no_stale_ready", {31'b0, o_ready}, 32'h0);
      applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
      checkOutput("tp3_reissue_valid", {31'b0, o_mvalid}, 32'h1);
      checkOutput("tp3_reissue_addr", o_maddr, 32'h400);

      $display("[TB] repeated address from hold");
      doReset();
      applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h502, 1'b0, 1'b1, 32'hCAFE_0500);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
         checkOutput("tp4_hold_ready", {31'b0, o_ready}, 32'h1);
         checkOutput("tp4_hold_rdata", o_rdata, 32'hCAFE_0500);
      end

      $display("[TB] address wrap");
      doReset();
      applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234_5678);
      applyStimulus(1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0);
      checkOutput("tp5_wrap_addr", o_maddr, 32'h0);
      checkOutput("tp5_wrap_valid", {31'b0, o_mvalid}, 32'h1);

      $display("[TB] randomized stream");
      doReset();
      pf = 32'h1000;
      for (int n = 0; n < 3000; n++) begin
         f  = ($urandom_range(0, 15) == 0);
         mr = ($urandom_range(0, 2) != 0);
         if (f) begin
            if ($urandom_range(0, 7) == 0) pf = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else pf = 32'h1000 + ($urandom & 32'hFF);
         end else if ($urandom_range(0, 24) == 0) begin
            pf = pf + 32'd8;
         end
         if ($urandom_range(0, 299) == 0) begin
            applyStimulus(1'b0, pf, f, mr, $urandom);
         end else begin
            applyStimulus(1'b1, pf, f, mr, mr ? mem_word({m_req[31:2], 2'b00}) : $urandom);
         end
         if (m_ready_exp) pf = pf + 32'd4;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
